// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder; the only arithmetic element of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (w_p & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through a single full-adder cell.
// Optional signed-overflow output ovf is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_s_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_s_sr_next;

  full_adder_cell u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts the LSB holds bit 0.
  assign w_s_sr_next = {w_s, r_s_sr};

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_s_sr  <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_s_sr  <= w_s_sr_next[WIDTH-1:1];
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_s_sr_next;
            r_cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
            // r_carry here is the carry into the MSB.
            r_ovf  <= r_carry ^ w_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 directed/random, WIDTH=2 exhaustive).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf2;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .cout(cout2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         disturb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One WIDTH=8 transaction; disturb>0 drives a spurious start sampled at that edge after acceptance.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input logic [7:0] esum, input logic ecout, input logic eovf,
                     input int disturb, input string tag);
    int  k;
    bit  seen;
    bit  busy_bad;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    seen = 0; busy_bad = 0;
    for (k = 1; k <= 12; k++) begin
      if (k == disturb) begin start = 1'b1; a = 8'hAA; end
      @(posedge clk); #1;
      start = 1'b0;
      if (!busy) busy_bad = 1;
      if (done) begin seen = 1; break; end
    end
    if (!seen) k = 99;
    chk({tag, "_latency"}, 32'(k), 32'd8);
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
    $display("op %s a=%02h b=%02h cin=%0b -> sum=%02h cout=%0b", tag, ta, tb_v, tc, sum, cout);
    @(posedge clk); #1;
    chk({tag, "_done_once"}, 32'({done, busy}), 32'd0);
    chk({tag, "_hold"}, 32'({cout, sum}), 32'({ecout, esum}));
  endtask

  // Reference model: plain integer addition and sign-rule overflow.
  task automatic op8_model(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           input int disturb, input string tag);
    int   total;
    logic [8:0] r;
    logic eovf;
    total = int'(ta) + int'(tb_v) + int'(tc);
    r     = 9'(total);
    eovf  = (ta[7] == tb_v[7]) && (r[7] != ta[7]);
    op8(ta, tb_v, tc, r[7:0], r[8], eovf, disturb, tag);
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 3};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[6] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out8", 32'({busy, done, cout, sum}), 32'd0);
    chk("reset_out2", 32'({busy2, done2, cout2, sum2}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
          vecs[i].disturb, $sformatf("vec%0d", i));

    // Reset mid-operation.
    begin
      bit bad;
      @(negedge clk);
      start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out", 32'({busy, done, cout, sum}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (done || busy) bad = 1;
      end
      chk("midrst_nodone", 32'(bad), 32'd0);
      $display("op midrst a=f0 b=0f aborted");
      op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0, "post_rst");
    end

    for (int i = 0; i < 30; i++) begin
      int d;
      d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
      op8_model(8'($urandom), 8'($urandom), 1'($urandom), d, $sformatf("rnd%0d", i));
    end

    // Exhaustive WIDTH=2.
    for (int i = 0; i < 32; i++) begin
      int  k;
      bit  seen;
      logic [4:0] v;
      int  exp;
      v = 5'(i);
      exp = int'(v[4:3]) + int'(v[2:1]) + int'(v[0]);
      @(negedge clk);
      start2 = 1'b1; a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
      @(posedge clk); #1;
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
      seen = 0;
      for (k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        if (done2) begin seen = 1; break; end
      end
      if (!seen) k = 99;
      chk($sformatf("w2_%0d_latency", i), 32'(k), 32'd2);
      chk($sformatf("w2_%0d_result", i), 32'({cout2, sum2}), 32'(exp));
      $display("op w2 a=%0d b=%0d cin=%0b -> {cout,sum}=%0d", v[4:3], v[2:1], v[0], {cout2, sum2});
      @(posedge clk); #1;
      chk($sformatf("w2_%0d_once", i), 32'({done2, busy2}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
